// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states,
// parity encodings and configuration limits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver result bundle: last good frame plus
// one-cycle outcome pulses towards the system controller.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  break_det;

    modport master (
        output P_DATA, data_valid, parity_error,
        output framing_error, break_det
    );

    modport slave (
        input P_DATA, data_valid, parity_error,
        input framing_error, break_det
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: edge counter, frame bit
// index and 3-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int IDX_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rx,
    input  logic               run,
    input  logic [PRESC_W-1:0] p,
    output logic [IDX_W-1:0]   bit_idx,
    output logic               sampled_bit,
    output logic               bit_done,
    output logic               bit_end
);
    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);
    localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic               s0;
    logic               s1;

    assign half        = p >> 1;
    assign bit_done    = edge_cnt == half;
    assign bit_end     = edge_cnt == p - ONE;
    assign sampled_bit = maj3(s0, s1, rx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else if (!run) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
            if (bit_done)
                bit_idx <= bit_idx + IDX_ONE;
            if (edge_cnt == half - TWO)
                s0 <= rx;
            if (edge_cnt == half - ONE)
                s1 <= rx;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, optional
// parity, 1/2 stop bits, glitch rejection and break detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    uart_rx_cfg_if.master      rx_if
);
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_DATA_END = IDX_W'(DATA_WIDTH + 1);

    uart_state_e state, nxt;

    logic [PRESC_W-1:0]    p_q;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic [DATA_WIDTH-1:0] shreg, p_data_q;
    logic                  par_err_q, all_zero_q;
    logic                  dv_q, pe_q, fe_q, bd_q;
    logic                  run, sampled_bit, bit_done, bit_end;
    logic [IDX_W-1:0]      bit_idx, first_stop, last_stop;
    logic                  start_seen, stop_bad, frame_end;
    logic                  exp_par, is_break;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W),
        .IDX_W   (IDX_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx          (RX_IN),
        .run         (run),
        .p           (p_q),
        .bit_idx     (bit_idx),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done),
        .bit_end     (bit_end)
    );

    assign start_seen = (state == IDLE) && !RX_IN;
    assign first_stop = LAST_DATA_END + {{(IDX_W-1){1'b0}}, par_en_q};
    assign last_stop  = first_stop + {{(IDX_W-1){1'b0}}, stop2_q};
    assign stop_bad   = (state == STOP) && bit_done && !sampled_bit;
    assign frame_end  = (state == STOP) && bit_done &&
                        (stop_bad || bit_idx == last_stop);
    assign exp_par    = (par_typ_q == PAR_ODD) ? ~^shreg : ^shreg;
    assign is_break   = all_zero_q && bit_idx == first_stop;
    // Counter runs whenever the next cycle belongs to a frame.
    assign run        = nxt inside {START, DATA, PARITY, STOP};

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:
                if (!RX_IN) nxt = START;
            START:
                if (bit_done && sampled_bit) nxt = IDLE;
                else if (bit_end)            nxt = DATA;
            DATA:
                if (bit_end && bit_idx == LAST_DATA_END)
                    nxt = par_en_q ? PARITY : STOP;
            PARITY:
                if (bit_end) nxt = STOP;
            STOP:
                if (stop_bad)       nxt = WAIT_IDLE;
                else if (frame_end) nxt = IDLE;
            WAIT_IDLE:
                if (RX_IN) nxt = IDLE;
            default:
                nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q        <= PRESC_W'(MIN_PRESCALE);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            stop2_q    <= 1'b0;
            shreg      <= '0;
            p_data_q   <= '0;
            par_err_q  <= 1'b0;
            all_zero_q <= 1'b1;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bd_q       <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= 1'b0;
            bd_q <= 1'b0;
            if (start_seen) begin
                p_q        <= Prescale & ~PRESC_W'(1);
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                stop2_q    <= STOP2;
                par_err_q  <= 1'b0;
                all_zero_q <= 1'b1;
            end
            if (bit_done && (state == DATA || state == PARITY))
                all_zero_q <= all_zero_q & ~sampled_bit;
            if (bit_done && state == DATA)
                shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            if (bit_done && state == PARITY)
                par_err_q <= sampled_bit != exp_par;
            if (frame_end) begin
                if (stop_bad) begin
                    fe_q <= 1'b1;
                    bd_q <= is_break;
                    pe_q <= par_err_q && !is_break;
                end else if (par_err_q) begin
                    pe_q <= 1'b1;
                end else begin
                    dv_q     <= 1'b1;
                    p_data_q <= shreg;
                end
            end
        end
    end

    assign rx_if.P_DATA        = p_data_q;
    assign rx_if.data_valid    = dv_q;
    assign rx_if.parity_error  = pe_q;
    assign rx_if.framing_error = fe_q;
    assign rx_if.break_det     = bd_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed + random frames on 8- and 9-bit receivers, checked
// against a frame-level model of expected outcome pulses.
module tb_uart_rx_cfg;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx9 = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;

    uart_rx_cfg_if #(.DATA_WIDTH(8)) if8 ();
    uart_rx_cfg_if #(.DATA_WIDTH(9)) if9 ();

    uart_rx_cfg #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (
        .CLK(CLK), .RST(RST), .RX_IN(rx8), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .rx_if(if8)
    );
    uart_rx_cfg #(.DATA_WIDTH(9), .PRESC_W(6)) dut9 (
        .CLK(CLK), .RST(RST), .RX_IN(rx9), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .rx_if(if9)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
        logic [8:0] data;
    } ev_t;

    ev_t got8[$], got9[$], exp8[$], exp9[$];
    logic       wave[$];
    logic [8:0] last8 = '0;
    logic [8:0] last9 = '0;
    int n_chk = 0;
    int n_fail = 0;

    always @(negedge CLK) begin
        if (if8.data_valid | if8.parity_error | if8.framing_error | if8.break_det)
            got8.push_back('{cyc, {if8.data_valid, if8.parity_error,
                                   if8.framing_error, if8.break_det},
                             {1'b0, if8.P_DATA}});
        if (if9.data_valid | if9.parity_error | if9.framing_error | if9.break_det)
            got9.push_back('{cyc, {if9.data_valid, if9.parity_error,
                                   if9.framing_error, if9.break_det},
                             if9.P_DATA});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cfg(input int p, input bit pe, input bit pt, input bit s2);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
    endtask

    task automatic add_bits(input logic b, input int n);
        repeat (n) wave.push_back(b);
    endtask

    // Outcome of one frame from its ideal bit levels; off = start cycle in wave.
    task automatic model(input int sel, input logic bits[$], input int dw,
                         input int p, input bit pe, input bit pt, input bit s2,
                         input int off);
        int         fs = 1 + dw + int'(pe);
        int         nst = s2 ? 2 : 1;
        int         end_k = fs + nst - 1;
        logic [8:0] d = '0;
        bit         fe = 0, allz = 1, brk, perr, good;
        ev_t        e;
        for (int i = 1; i <= dw; i++) d[i-1] = bits[i];
        perr = pe && (bits[dw+1] != (pt ? ~^d : ^d));
        for (int s = 0; s < nst; s++)
            if (!fe && bits[fs+s] == 1'b0) begin
                fe = 1;
                end_k = fs + s;
            end
        for (int i = 1; i <= fs; i++) if (bits[i]) allz = 0;
        brk  = fe && allz;
        if (brk) perr = 0;
        good = !fe && !perr;
        if (good) begin
            if (sel != 0) last9 = d; else last8 = d;
        end
        e.cyc   = off + end_k * p + p / 2 + 1;
        e.flags = {good, perr, fe, brk};
        e.data  = (sel != 0) ? last9 : last8;
        if (sel != 0) exp9.push_back(e); else exp8.push_back(e);
    endtask

    task automatic build(input int sel, input logic [8:0] data, input int p,
                         input bit pe, input bit pt, input bit s2, input bit bad_par,
                         input logic st1, input logic st2, input bit do_model);
        int   dw = (sel != 0) ? 9 : 8;
        int   off = wave.size();
        logic bits[$];
        logic par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(data[i]);
            par ^= data[i];
        end
        if (pt) par = ~par;
        if (bad_par) par = ~par;
        if (pe) bits.push_back(par);
        bits.push_back(st1);
        if (s2) bits.push_back(st2);
        foreach (bits[i]) add_bits(bits[i], p);
        if (do_model) model(sel, bits, dw, p, pe, pt, s2, off);
    endtask

    task automatic play(input int sel, input int chg_at, input logic [5:0] chg_val,
                        output int start);
        start = cyc;
        foreach (wave[i]) begin
            if (i == chg_at) Prescale = chg_val;
            if (sel != 0) rx9 = wave[i]; else rx8 = wave[i];
            @(posedge CLK);
            #1;
        end
        rx8 = 1'b1;
        rx9 = 1'b1;
        wave = {};
    endtask

    task automatic compare(input int sel, input int start, input string tag);
        ev_t g[$], e[$];
        idle(3);
        if (sel != 0) begin
            g = got9; e = exp9; got9 = {}; exp9 = {};
            chk({tag, ".pdata"}, 32'(if9.P_DATA), 32'(last9));
        end else begin
            g = got8; e = exp8; got8 = {}; exp8 = {};
            chk({tag, ".pdata"}, 32'(if8.P_DATA), 32'(last8));
        end
        chk({tag, ".count"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            chk({tag, ".cycle"}, g[i].cyc - start, e[i].cyc);
            chk({tag, ".flags"}, 32'(g[i].flags), 32'(e[i].flags));
            chk({tag, ".data"}, 32'(g[i].data), 32'(e[i].data));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".p8"}, 32'(if8.P_DATA), 0);
        chk({tag, ".p9"}, 32'(if9.P_DATA), 0);
        chk({tag, ".pulse8"}, 32'({if8.data_valid, if8.parity_error,
                                   if8.framing_error, if8.break_det}), 0);
        chk({tag, ".pulse9"}, 32'({if9.data_valid, if9.parity_error,
                                   if9.framing_error, if9.break_det}), 0);
    endtask

    initial begin
        int         t;
        int         sel, p;
        bit         pe, pt, s2, bp;
        logic       st1, st2;
        logic [8:0] d;

        idle(3);
        chk_reset("reset");
        RST = 1'b1;
        idle(3);

        cfg(8, 0, 0, 0);
        build(0, 9'h0A5, 8, 0, 0, 0, 0, 1, 1, 1);
        play(0, -1, 6'd0, t);
        compare(0, t, "good_a5");

        cfg(8, 1, 0, 0);
        build(0, 9'h03C, 8, 1, 0, 0, 1, 1, 1, 1);
        play(0, -1, 6'd0, t);
        compare(0, t, "par_even_bad");
        cfg(8, 1, 1, 0);
        build(0, 9'h03C, 8, 1, 1, 0, 0, 1, 1, 1);
        play(0, -1, 6'd0, t);
        compare(0, t, "par_odd_ok");

        cfg(16, 0, 0, 0);
        add_bits(1'b0, 5);
        add_bits(1'b1, 11);
        build(0, 9'h0C3, 16, 0, 0, 0, 0, 1, 1, 1);
        wave[16 + 3 * 16 + 7] = ~wave[16 + 3 * 16 + 7];
        play(0, -1, 6'd0, t);
        compare(0, t, "glitch_spike");

        cfg(16, 0, 0, 1);
        build(1, 9'h12D, 16, 0, 0, 1, 0, 1, 0, 1);
        add_bits(1'b0, 12 * 16);
        add_bits(1'b1, 4);
        build(1, 9'h0AB, 16, 0, 0, 1, 0, 1, 1, 1);
        play(1, -1, 6'd0, t);
        compare(1, t, "stop2_fe");

        build(1, 9'h1FF, 16, 0, 0, 1, 0, 1, 1, 1);
        build(1, 9'h001, 16, 0, 0, 1, 0, 1, 1, 1);
        play(1, -1, 6'd0, t);
        compare(1, t, "b2b");

        cfg(8, 1, 1, 0);
        build(0, 9'h000, 8, 1, 1, 0, 1, 0, 0, 1);
        add_bits(1'b0, 2 * 11 * 8);
        add_bits(1'b1, 3);
        build(0, 9'h05E, 8, 1, 1, 0, 0, 1, 1, 1);
        play(0, -1, 6'd0, t);
        compare(0, t, "break");

        cfg(8, 0, 0, 0);
        build(0, 9'h05A, 8, 0, 0, 0, 0, 1, 1, 0);
        wave = wave[0:26];
        play(0, -1, 6'd0, t);
        rx8 = 1'b0;
        RST = 1'b0;
        #1;
        chk_reset("rst_mid");
        last8 = '0;
        last9 = '0;
        rx8 = 1'b1;
        idle(3);
        RST = 1'b1;
        compare(0, t, "rst_abort");
        compare(1, t, "rst_abort9");
        build(0, 9'h0E7, 8, 0, 0, 0, 0, 1, 1, 1);
        play(0, -1, 6'd0, t);
        compare(0, t, "post_rst");

        cfg(10, 0, 0, 0);
        build(0, 9'h096, 10, 0, 0, 0, 0, 1, 1, 1);
        play(0, 25, 6'd20, t);
        compare(0, t, "presc_chg");

        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 1));
            p   = 2 * int'($urandom_range(4, 31));
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            s2  = 1'($urandom_range(0, 1));
            bp  = ($urandom_range(0, 3) == 0);
            st1 = ($urandom_range(0, 7) != 0);
            st2 = ($urandom_range(0, 7) != 0);
            d   = 9'($urandom);
            if (sel == 0) d[8] = 1'b0;
            cfg(p, pe, pt, s2);
            Prescale = Prescale | 6'($urandom_range(0, 1));
            build(sel, d, p, pe, pt, s2, bp, st1, st2, 1);
            add_bits(1'b1, 2);
            play(sel, -1, 6'd0, t);
            compare(sel, t, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
